rx_dequeue_ctrl: RTL and testbench

Receive-side dequeue controller between the RX data FIFO (72-bit entries: 8-bit status plus 64-bit data, show-ahead read) and the user packet interface in the 156.25 MHz domain. It converts user read requests into FIFO pops and enforces SOP/EOP framing. It discards orphan words that arrive without a start-of-packet, terminates frames whose EOP never arrived, and optionally keeps frame statistics.

---
 rtl/rx_dequeue_ctrl.sv | 118 +++++++++++
 tb/tb_rx_dequeue_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rx_dequeue_ctrl.sv
// rx_dequeue_ctrl: RX FIFO to packet interface dequeue with SOP/EOP framing; RX_DEQ_STATS_EN enables frame statistics counters.
module rx_dequeue_ctrl #(
  parameter logic [15:0] DROP_LIMIT = 16'hFFFF
) (
  input  logic        clk_156m25,
  input  logic        reset_156m25,
  input  logic [63:0] rxdfifo_rdata,
  input  logic [7:0]  rxdfifo_rstatus,
  input  logic        rxdfifo_rempty,
  output logic        rxdfifo_ren,
  input  logic        pkt_rx_ren,
  output logic        pkt_rx_avail,
  output logic        pkt_rx_val,
  output logic        pkt_rx_sop,
  output logic        pkt_rx_eop,
  output logic        pkt_rx_err,
  output logic [63:0] pkt_rx_data,
  output logic [2:0]  pkt_rx_mod,
  output logic [31:0] stat_rx_frames,
  output logic [31:0] stat_rx_err_frames,
  output logic [31:0] stat_rx_drop_words
);
  typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;
  state_t state, state_nx;
  logic [15:0] drop_run;
  logic head_ok, head_sop, head_eop, head_err;
  logic pop, beat, synth, drop_pop, word;
  logic unused_status;
  assign head_ok  = !rxdfifo_rempty;
  assign head_sop = rxdfifo_rstatus[7];
  assign head_eop = rxdfifo_rstatus[6];
  assign head_err = rxdfifo_rstatus[5];
  assign unused_status = ^rxdfifo_rstatus[4:3];
  assign rxdfifo_ren = pop;
  assign word = beat && !synth;
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    beat = 1'b0;
    synth = 1'b0;
    drop_pop = 1'b0;
    case (state)
      IDLE: if (head_ok) begin
        if (head_sop) begin
          pop = pkt_rx_ren;
          beat = pkt_rx_ren;
          if (pkt_rx_ren && !head_eop) state_nx = XFER;
        end else begin
          pop = 1'b1;
          drop_pop = 1'b1;
          if (!head_eop && DROP_LIMIT > 16'd1) state_nx = DROP;
        end
      end
      XFER: if (head_ok && pkt_rx_ren) begin
        beat = 1'b1;
        if (head_sop) begin
          synth = 1'b1;
          state_nx = IDLE;
        end else begin
          pop = 1'b1;
          if (head_eop) state_nx = IDLE;
        end
      end
      DROP: if (head_ok) begin
        if (head_sop) state_nx = IDLE;
        else begin
          pop = 1'b1;
          drop_pop = 1'b1;
          if (head_eop || drop_run + 16'd1 >= DROP_LIMIT) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      state <= IDLE;
      drop_run <= '0;
      pkt_rx_avail <= 1'b0;
      pkt_rx_val <= 1'b0;
      pkt_rx_sop <= 1'b0;
      pkt_rx_eop <= 1'b0;
      pkt_rx_err <= 1'b0;
      pkt_rx_mod <= '0;
      pkt_rx_data <= '0;
    end else begin
      state <= state_nx;
      drop_run <= drop_pop ? (state == DROP ? drop_run + 16'd1 : 16'd1) : drop_run;
      pkt_rx_avail <= head_ok && (state == XFER || head_sop);
      pkt_rx_val <= beat;
      pkt_rx_sop <= word && head_sop;
      pkt_rx_eop <= synth || (word && head_eop);
      pkt_rx_err <= synth || (word && head_err);
      pkt_rx_mod <= (word && head_eop) ? rxdfifo_rstatus[2:0] : 3'd0;
      pkt_rx_data <= word ? rxdfifo_rdata : 64'd0;
    end
  end
`ifdef RX_DEQ_STATS_EN
  logic eop_beat, err_beat;
  assign eop_beat = synth || (word && head_eop);
  assign err_beat = synth || (word && head_eop && head_err);
  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      stat_rx_frames <= '0;
      stat_rx_err_frames <= '0;
      stat_rx_drop_words <= '0;
    end else begin
      if (eop_beat && !(&stat_rx_frames)) stat_rx_frames <= stat_rx_frames + 32'd1;
      if (err_beat && !(&stat_rx_err_frames)) stat_rx_err_frames <= stat_rx_err_frames + 32'd1;
      if (drop_pop && !(&stat_rx_drop_words)) stat_rx_drop_words <= stat_rx_drop_words + 32'd1;
    end
  end
`else
  assign stat_rx_frames = '0;
  assign stat_rx_err_frames = '0;
  assign stat_rx_drop_words = '0;
`endif
endmodule

// File: tb/tb_rx_dequeue_ctrl.sv
// tb_rx_dequeue_ctrl: scoreboard bench for rx_dequeue_ctrl with a show-ahead FIFO model.
module tb_rx_dequeue_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [63:0] rxdfifo_rdata, pkt_rx_data;
  logic [7:0] rxdfifo_rstatus;
  logic rxdfifo_rempty, rxdfifo_ren, pkt_rx_ren, pkt_rx_avail;
  logic pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err;
  logic [2:0] pkt_rx_mod;
  logic [31:0] stat_rx_frames, stat_rx_err_frames, stat_rx_drop_words;
  rx_dequeue_ctrl dut (
    .clk_156m25(clk), .reset_156m25(rst),
    .rxdfifo_rdata(rxdfifo_rdata), .rxdfifo_rstatus(rxdfifo_rstatus),
    .rxdfifo_rempty(rxdfifo_rempty), .rxdfifo_ren(rxdfifo_ren),
    .pkt_rx_ren(pkt_rx_ren), .pkt_rx_avail(pkt_rx_avail),
    .pkt_rx_val(pkt_rx_val), .pkt_rx_sop(pkt_rx_sop), .pkt_rx_eop(pkt_rx_eop),
    .pkt_rx_err(pkt_rx_err), .pkt_rx_data(pkt_rx_data), .pkt_rx_mod(pkt_rx_mod),
    .stat_rx_frames(stat_rx_frames), .stat_rx_err_frames(stat_rx_err_frames),
    .stat_rx_drop_words(stat_rx_drop_words)
  );
`ifdef RX_DEQ_STATS_EN
  localparam int SE = 1;
`else
  localparam int SE = 0;
`endif
  typedef struct packed {
    logic sop;
    logic eop;
    logic err;
    logic [2:0] mod;
    logic [63:0] data;
  } beat_t;
  beat_t exp_q[$];
  beat_t exp_b;
  int errs = 0, checks = 0;
  logic [71:0] mem [64];
  int wr = 0, rd = 0;
  logic ren_last = 1'b0;
  int cnt;
  assign rxdfifo_rempty = (wr == rd);
  assign {rxdfifo_rstatus, rxdfifo_rdata} = mem[rd % 64];
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [7:0] st, input logic [63:0] d);
    mem[wr % 64] = {st, d};
    wr++;
  endtask
  task automatic expect_beat(input logic s, input logic e, input logic r, input logic [2:0] m, input logic [63:0] d);
    exp_q.push_back('{sop: s, eop: e, err: r, mod: m, data: d});
  endtask
  task automatic drain();
    int n = 0;
    while ((wr != rd || exp_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_fifo", wr - rd, 0);
    check("drain_beats", exp_q.size(), 0);
  endtask
  task automatic check_stats(input int fr, input int ef, input int dw);
    check("stat_frames", stat_rx_frames, fr * SE);
    check("stat_err_frames", stat_rx_err_frames, ef * SE);
    check("stat_drop_words", stat_rx_drop_words, dw * SE);
  endtask
  always @(posedge clk) begin
    if (rxdfifo_ren) begin
      check("ren_while_empty", rxdfifo_rempty, 0);
      rd <= rd + 1;
    end
    ren_last <= pkt_rx_ren;
  end
  always @(negedge clk) begin
    if (pkt_rx_val) begin
      check("beat_after_ren", ren_last, 1);
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_beat: got sop=%0b eop=%0b err=%0b mod=%0d data=%0h expected no beat",
                 pkt_rx_sop, pkt_rx_eop, pkt_rx_err, pkt_rx_mod, pkt_rx_data);
      end else begin
        exp_b = exp_q.pop_front();
        check("beat", {pkt_rx_sop, pkt_rx_eop, pkt_rx_err, pkt_rx_mod, pkt_rx_data}, exp_b);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    pkt_rx_ren = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_val", pkt_rx_val, 0);
    check("rst_flags", {pkt_rx_sop, pkt_rx_eop, pkt_rx_err, pkt_rx_mod}, 0);
    check("rst_data", pkt_rx_data, 0);
    check("rst_avail", pkt_rx_avail, 0);
    check("rst_stats", {stat_rx_frames, stat_rx_err_frames, stat_rx_drop_words}, 0);
    pkt_rx_ren = 1'b1;
    push(8'h83, 64'h1111_0000_AAAA_0001);
    push(8'h00, 64'h2222_0000_AAAA_0002);
    push(8'h43, 64'h3333_0000_AAAA_0003);
    expect_beat(1, 0, 0, 0, 64'h1111_0000_AAAA_0001);
    expect_beat(0, 0, 0, 0, 64'h2222_0000_AAAA_0002);
    expect_beat(0, 1, 0, 3, 64'h3333_0000_AAAA_0003);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_consecutive", pkt_rx_val, 1);
    end
    drain();
    check_stats(1, 0, 0);
    push(8'hC0, 64'hDEADBEEF_01234567);
    expect_beat(1, 1, 0, 0, 64'hDEADBEEF_01234567);
    drain();
    check_stats(2, 0, 0);
    pkt_rx_ren = 1'b0;
    push(8'h00, 64'h0BAD_0000_0000_0001);
    push(8'h00, 64'h0BAD_0000_0000_0002);
    push(8'h80, 64'h4444_0000_0000_0001);
    push(8'h40, 64'h4444_0000_0000_0002);
    repeat (5) @(negedge clk);
    check("t3_avail", pkt_rx_avail, 1);
    check("t3_fifo_left", wr - rd, 2);
    check_stats(2, 0, 2);
    expect_beat(1, 0, 0, 0, 64'h4444_0000_0000_0001);
    expect_beat(0, 1, 0, 0, 64'h4444_0000_0000_0002);
    pkt_rx_ren = 1'b1;
    drain();
    check_stats(3, 0, 2);
    push(8'h80, 64'h5555_0000_0000_0001);
    push(8'h00, 64'h5555_0000_0000_0002);
    push(8'h80, 64'h6666_0000_0000_0001);
    push(8'h47, 64'h6666_0000_0000_0002);
    expect_beat(1, 0, 0, 0, 64'h5555_0000_0000_0001);
    expect_beat(0, 0, 0, 0, 64'h5555_0000_0000_0002);
    expect_beat(0, 1, 1, 0, 64'h0);
    expect_beat(1, 0, 0, 0, 64'h6666_0000_0000_0001);
    expect_beat(0, 1, 0, 7, 64'h6666_0000_0000_0002);
    drain();
    check_stats(5, 1, 2);
    pkt_rx_ren = 1'b0;
    @(negedge clk);
    push(8'h80, 64'h7777_0000_0000_0001);
    push(8'h00, 64'h7777_0000_0000_0002);
    push(8'h20, 64'h7777_0000_0000_0003);
    push(8'h45, 64'h7777_0000_0000_0004);
    expect_beat(1, 0, 0, 0, 64'h7777_0000_0000_0001);
    expect_beat(0, 0, 0, 0, 64'h7777_0000_0000_0002);
    expect_beat(0, 0, 1, 0, 64'h7777_0000_0000_0003);
    expect_beat(0, 1, 0, 5, 64'h7777_0000_0000_0004);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (pkt_rx_val) cnt++;
      pkt_rx_ren = (i % 2 == 0);
    end
    check("t5_beats", cnt, 4);
    drain();
    check_stats(6, 1, 2);
    pkt_rx_ren = 1'b1;
    push(8'h80, 64'h8888_0000_0000_0001);
    push(8'h00, 64'h8888_0000_0000_0002);
    push(8'h40, 64'h8888_0000_0000_0003);
    expect_beat(1, 0, 0, 0, 64'h8888_0000_0000_0001);
    @(negedge clk);
    check("t6_sop_beat", pkt_rx_val, 1);
    pkt_rx_ren = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_val", pkt_rx_val, 0);
    check("t6_rst_flags", {pkt_rx_sop, pkt_rx_eop, pkt_rx_err, pkt_rx_mod}, 0);
    check("t6_rst_data", pkt_rx_data, 0);
    check("t6_rst_avail", pkt_rx_avail, 0);
    check_stats(0, 0, 0);
    repeat (4) @(negedge clk);
    check("t6_fifo_left", wr - rd, 0);
    check("t6_beats_left", exp_q.size(), 0);
    check_stats(0, 0, 2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
